hazard_control: RTL and testbench
=================================

# hazard_control

Pipeline hazard controller that generates the select and enable signals driving the datapath operand muxes, PC/IF-ID write enables and the IF/ID squash of the 5-stage MIPS pipeline. It keeps a shadow copy of the destination-register state of the EX, MEM and WB stages. From that state and the decoded ID-stage instruction it produces:
- registered forwarding selects for the EX-stage operand muxes,
- ID-stage branch-operand forwarding,
- load-use and branch-dependency stalls,
- taken-branch flushes.

It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_BITS, 16, width of each saturating event counter

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous active-low reset
- IdRs  input  5  rs field of instruction in ID
- IdRt  input  5  rt field of instruction in ID
- IdUsesRs  input  1  ID instruction reads rs
- IdUsesRt  input  1  ID instruction reads rt
- IdDest  input  5  destination register of ID instruction (already rd/rt-selected)
- IdRegWrite  input  1  ID instruction writes the register file
- IdMemRead  input  1  ID instruction is a load
- IdBranch  input  1  ID instruction is a branch compared in ID
- BranchTaken  input  1  ID branch comparison result, valid when IdBranch=1
- Stall  output  1  hold PC and IF/ID, bubble into ID/EX; combinational
- Flush  output  1  squash IF/ID contents; combinational
- ForwardA  output  2  EX operand A mux select; registered
- ForwardB  output  2  EX operand B mux select; registered
- BrForwardA  output  1  ID branch operand A takes EX/MEM ALU result
- BrForwardB  output  1  ID branch operand B takes EX/MEM ALU result
- StallCount  output  CNT_BITS  cycles with Stall=1, saturating
- FlushCount  output  CNT_BITS  cycles with Flush=1, saturating

## Operation
- Shadow state:
  - Per stage S in {Ex, Mem, Wb}: SDest[4:0], SRegWrite, SMemRead.
  - Each rising edge shifts Ex→Mem→Wb.
  - Ex loads the ID fields, or a bubble (RegWrite=0, MemRead=0, Dest=0) when Stall=1.
- Match rule: a source matches stage S when the source is used, SRegWrite=1, SDest==source and source≠0. Register 0 never matches.
- Stall=1 when any of the following holds:
  - (a) Ex is a load matching rs or rt (load-use);
  - (b) IdBranch=1 and Ex matches rs or rt (load or ALU);
  - (c) IdBranch=1 and Mem is a load matching rs or rt.
- Resulting stall lengths:
  - Load-use: 1 cycle.
  - Branch on ALU result in Ex: 1 cycle.
  - Branch on load in Ex: 2 cycles.
- Flush = IdBranch & BranchTaken & ~Stall.
- BrForwardA/B = IdBranch & Mem match on rs/rt & ~MemMemRead; combinational. The WB stage needs no ID forwarding because the register file is write-first.
- Forward encoding: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB writeback value.
- ForwardA/B next value, computed from the ID instruction:
  - 10 if current Ex matches.
  - Else 01 if current Mem matches.
  - Else 00.
  - Forced to 00 when Stall=1 (bubble).
- The next value is captured at the same edge the instruction enters EX, so the select is valid for exactly its EX cycle.
- Counters increment on each edge where the event signal is 1 and hold at all-ones.

## Timing
- Reset (asynchronous, ResetN=0):
  - All shadow RegWrite/MemRead/Dest = 0.
  - ForwardA = ForwardB = 00.
  - StallCount = FlushCount = 0.
  - Stall, Flush, BrForwardA and BrForwardB therefore evaluate to 0 (given IdBranch inputs).
- Reset mid-stall clears all state immediately. The first cycle after release sees an empty pipeline.
- Stall, Flush and BrForward* settle in the same cycle as the ID inputs, with zero latency. ForwardA/B have 1-cycle latency from ID.
- Simultaneous events:
  - Stall suppresses Flush. The branch re-evaluates after the stall.
  - Ex and Mem both matching the same register gives 10 (newest wins).
- A load in Mem that matches a non-branch ID instruction is not a stall. It resolves to Forward 01 next cycle.

## Test plan
- Load-use: ID `lw $5` then ID `add $6,$5,$7` (IdRs=5). Required response:
  - Stall=1 for 1 cycle.
  - The following cycle the add re-presents and ForwardA=01 on its EX cycle.
  - StallCount=1.
- ALU chain: `add $3` then `sub $4,$3,$3`. Required response:
  - No stall.
  - ForwardA=ForwardB=10 in sub's EX cycle.
  - A third instruction using $3 gets 01.
- Branch on load: `lw $8` then `beq $8,$0` taken. Required response:
  - Stall=1 for 2 cycles with Flush=0.
  - Then Flush=1 for 1 cycle.
  - FlushCount=1.
- Branch on ALU in Mem: `add $9`, `nop`, `beq $9,$9`. Required response:
  - BrForwardA=BrForwardB=1.
  - Stall=0.
  - Flush=1.
- Register 0: `add $0` then `or $1,$0,$0` → ForwardA=ForwardB=00 and no stall.
- Reset/saturation: assert ResetN=0 during a 2-cycle branch stall. Required response:
  - All outputs return to reset values at once.
  - With CNT_BITS=2 and 5 forced stall cycles, StallCount=3.

Source files
------------

// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard unit for the 5-stage MIPS datapath.
// Tracks destination-register state of the in-flight EX/MEM instructions and
// derives stall, flush, operand forwarding selects and saturating event counts.
module hazard_control #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic [4:0]          IdRs,
  input  logic [4:0]          IdRt,
  input  logic                IdUsesRs,
  input  logic                IdUsesRt,
  input  logic [4:0]          IdDest,
  input  logic                IdRegWrite,
  input  logic                IdMemRead,
  input  logic                IdBranch,
  input  logic                BranchTaken,
  output logic                Stall,
  output logic                Flush,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                BrForwardA,
  output logic                BrForwardB,
  output logic [CNT_BITS-1:0] StallCount,
  output logic [CNT_BITS-1:0] FlushCount
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  // The WB-stage shadow is not kept: the register file is write-first, so
  // nothing downstream ever consults it.
  logic [4:0]          ex_dest_q, ex_dest_d;
  logic                ex_regwrite_q, ex_regwrite_d;
  logic                ex_memread_q, ex_memread_d;
  logic [4:0]          mem_dest_q, mem_dest_d;
  logic                mem_regwrite_q, mem_regwrite_d;
  logic                mem_memread_q, mem_memread_d;
  logic [1:0]          fwd_a_q, fwd_a_d;
  logic [1:0]          fwd_b_q, fwd_b_d;
  logic [CNT_BITS-1:0] stall_count_q, stall_count_d;
  logic [CNT_BITS-1:0] flush_count_q, flush_count_d;

  logic ex_rs_match, ex_rt_match, mem_rs_match, mem_rt_match;

  function automatic logic src_match(input logic used, input logic [4:0] src,
                                     input logic regwrite, input logic [4:0] dest);
    return used && regwrite && (dest == src) && (src != 5'd0);
  endfunction

  // Hazard detection: stall/flush/branch forwarding settle with the ID inputs
  always_comb begin
    ex_rs_match  = src_match(IdUsesRs, IdRs, ex_regwrite_q, ex_dest_q);
    ex_rt_match  = src_match(IdUsesRt, IdRt, ex_regwrite_q, ex_dest_q);
    mem_rs_match = src_match(IdUsesRs, IdRs, mem_regwrite_q, mem_dest_q);
    mem_rt_match = src_match(IdUsesRt, IdRt, mem_regwrite_q, mem_dest_q);

    Stall = (ex_memread_q && (ex_rs_match || ex_rt_match))
         || (IdBranch && (ex_rs_match || ex_rt_match))
         || (IdBranch && mem_memread_q && (mem_rs_match || mem_rt_match));
    Flush      = IdBranch && BranchTaken && !Stall;
    BrForwardA = IdBranch && mem_rs_match && !mem_memread_q;
    BrForwardB = IdBranch && mem_rt_match && !mem_memread_q;
  end

  // Next shadow state, EX forwarding selects and saturating counters
  always_comb begin
    ex_dest_d      = IdDest;
    ex_regwrite_d  = IdRegWrite;
    ex_memread_d   = IdMemRead;
    mem_dest_d     = ex_dest_q;
    mem_regwrite_d = ex_regwrite_q;
    mem_memread_d  = ex_memread_q;
    fwd_a_d        = FWD_RF;
    fwd_b_d        = FWD_RF;
    stall_count_d  = stall_count_q;
    flush_count_d  = flush_count_q;

    if (Stall) begin
      ex_dest_d     = '0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
    end else begin
      if (ex_rs_match)       fwd_a_d = FWD_EX;
      else if (mem_rs_match) fwd_a_d = FWD_MEM;
      if (ex_rt_match)       fwd_b_d = FWD_EX;
      else if (mem_rt_match) fwd_b_d = FWD_MEM;
    end

    if (Stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_BITS'(1);
    if (Flush && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_BITS'(1);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      fwd_a_q        <= FWD_RF;
      fwd_b_q        <= FWD_RF;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign ForwardA   = fwd_a_q;
  assign ForwardB   = fwd_b_q;
  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: hand-computed expectations per step.
module tb_hazard_control;

  logic        Clk;
  logic        ResetN;
  logic [4:0]  IdRs, IdRt, IdDest;
  logic        IdUsesRs, IdUsesRt, IdRegWrite, IdMemRead, IdBranch, BranchTaken;

  logic        Stall, Flush, BrForwardA, BrForwardB;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] StallCount, FlushCount;

  logic        s_Stall, s_Flush, s_BrForwardA, s_BrForwardB;
  logic [1:0]  s_ForwardA, s_ForwardB;
  logic [1:0]  s_StallCount, s_FlushCount;

  int checks = 0;
  int errors = 0;

  hazard_control dut (
    .Clk(Clk), .ResetN(ResetN),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdDest(IdDest), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdBranch(IdBranch), .BranchTaken(BranchTaken),
    .Stall(Stall), .Flush(Flush), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .BrForwardA(BrForwardA), .BrForwardB(BrForwardB),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_control #(.CNT_BITS(2)) dut_small (
    .Clk(Clk), .ResetN(ResetN),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdDest(IdDest), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdBranch(IdBranch), .BranchTaken(BranchTaken),
    .Stall(s_Stall), .Flush(s_Flush), .ForwardA(s_ForwardA), .ForwardB(s_ForwardB),
    .BrForwardA(s_BrForwardA), .BrForwardB(s_BrForwardB),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                    input logic urt, input logic [4:0] dest, input logic rw,
                    input logic mr, input logic br, input logic tk);
    IdRs = rs; IdRt = rt; IdUsesRs = urs; IdUsesRt = urt; IdDest = dest;
    IdRegWrite = rw; IdMemRead = mr; IdBranch = br; BranchTaken = tk;
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN = 1'b0;
    nop();
    #3;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_flush", 32'(Flush), 32'd0);
    chk("rst_fwda", 32'(ForwardA), 32'd0);
    chk("rst_fwdb", 32'(ForwardB), 32'd0);
    chk("rst_brfwd", 32'({BrForwardA, BrForwardB}), 32'd0);
    chk("rst_scnt", 32'(StallCount), 32'd0);
    chk("rst_fcnt", 32'(FlushCount), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    tick();

    // load-use: lw $5 ; add $6,$5,$7
    id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_lw_nostall", 32'(Stall), 32'd0);
    tick();
    id(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_stall", 32'(Stall), 32'd1);
    chk("lu_noflush", 32'(Flush), 32'd0);
    tick();
    chk("lu_bubble_fwda", 32'(ForwardA), 32'd0);
    #1 chk("lu_release", 32'(Stall), 32'd0);
    tick();
    chk("lu_fwda", 32'(ForwardA), 32'b01);
    chk("lu_fwdb", 32'(ForwardB), 32'b00);
    chk("lu_scnt", 32'(StallCount), 32'd1);

    // ALU chain: add $3 ; sub $4,$3,$3 ; and $10,$3,$0
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("alu_nostall", 32'(Stall), 32'd0);
    tick();
    chk("alu_fwda", 32'(ForwardA), 32'b10);
    chk("alu_fwdb", 32'(ForwardB), 32'b10);
    id(5'd3, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("alu3_nostall", 32'(Stall), 32'd0);
    tick();
    chk("alu3_fwda", 32'(ForwardA), 32'b01);
    chk("alu3_fwdb", 32'(ForwardB), 32'b00);

    // branch on load: lw $8 ; beq $8,$0 taken
    id(5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    id(5'd8, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("bl_stall1", 32'(Stall), 32'd1);
    chk("bl_noflush1", 32'(Flush), 32'd0);
    tick();
    chk("bl_bubble_fwda", 32'(ForwardA), 32'd0);
    #1 chk("bl_stall2", 32'(Stall), 32'd1);
    chk("bl_noflush2", 32'(Flush), 32'd0);
    tick();
    #1 chk("bl_release", 32'(Stall), 32'd0);
    chk("bl_flush", 32'(Flush), 32'd1);
    chk("bl_nobrfwd", 32'({BrForwardA, BrForwardB}), 32'd0);
    tick();
    chk("bl_fcnt", 32'(FlushCount), 32'd1);
    chk("bl_scnt", 32'(StallCount), 32'd3);

    // branch on ALU result in MEM: add $9 ; nop ; beq $9,$9 taken
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    id(5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("ba_brfwda", 32'(BrForwardA), 32'd1);
    chk("ba_brfwdb", 32'(BrForwardB), 32'd1);
    chk("ba_nostall", 32'(Stall), 32'd0);
    chk("ba_flush", 32'(Flush), 32'd1);
    tick();
    chk("ba_fwda", 32'(ForwardA), 32'b01);
    chk("ba_fcnt", 32'(FlushCount), 32'd2);

    // register 0: add $0 ; or $1,$0,$0
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("r0_nostall", 32'(Stall), 32'd0);
    tick();
    chk("r0_fwda", 32'(ForwardA), 32'd0);
    chk("r0_fwdb", 32'(ForwardB), 32'd0);

    // EX and MEM both write $3: newest (EX) wins
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("both_fwda", 32'(ForwardA), 32'b10);
    chk("both_fwdb", 32'(ForwardB), 32'b10);

    // reset in the middle of a 2-cycle branch-on-load stall
    id(5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    id(5'd8, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk("mr_stall2", 32'(Stall), 32'd1);
    ResetN = 1'b0;
    #1 chk("mr_stall", 32'(Stall), 32'd0);
    chk("mr_fwda", 32'(ForwardA), 32'd0);
    chk("mr_fwdb", 32'(ForwardB), 32'd0);
    chk("mr_brfwd", 32'({BrForwardA, BrForwardB}), 32'd0);
    chk("mr_scnt", 32'(StallCount), 32'd0);
    chk("mr_fcnt", 32'(FlushCount), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    #1 chk("mr_post_stall", 32'(Stall), 32'd0);
    chk("mr_post_flush", 32'(Flush), 32'd1);
    tick();
    chk("mr_post_fcnt", 32'(FlushCount), 32'd1);
    chk("mr_post_scnt", 32'(StallCount), 32'd0);

    // counter saturation: five load-use stalls
    ResetN = 1'b0;
    nop();
    @(negedge Clk);
    ResetN = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      id(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk($sformatf("sat_stall%0d", i), 32'(s_Stall), 32'd1);
      tick();
    end
    nop();
    tick();
    chk("sat_small_scnt", 32'(s_StallCount), 32'd3);
    chk("sat_big_scnt", 32'(StallCount), 32'd5);
    chk("sat_small_fcnt", 32'(s_FlushCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
